// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and helpers for the PC fetch stage:
//                default vectors, kernel-mode bit position, PC width and
//                the branch-offset formatting function.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int          PC_W          = 32;
    localparam int          KMODE_BIT     = 31;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;

    // Sign-extended, word-scaled branch offset truncated to the 31 address
    // bits below the mode bit, so a branch can never touch PC[31].
    function automatic logic [30:0] branch_offset(input logic [15:0] imm);
        branch_offset = {{13{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/next_pc_calc.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_calc
//  Description : Purely combinational next-PC selection. Priority mux over
//                stall / irq / illegal-op / jr / jump / branch / sequential,
//                plus the mode-preserving PC+4 and branch adders.
//  Revision    : 1.0  initial release
// ============================================================================
module next_pc_calc
    import mips_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            irq,
    input  logic            illegal_op,
    input  logic            branch_taken,
    input  logic [15:0]     branch_imm,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            jr,
    input  logic [31:0]     jr_target,
    output logic [PC_W-1:0] next_pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            take_irq,
    output logic            take_exc
);

    logic            w_kmode;
    logic [30:0]     w_seq_low;
    logic [30:0]     w_br_low;
    logic [PC_W-1:0] w_jump_pc;
    logic [PC_W-1:0] w_br_pc;
    logic [PC_W-1:0] w_jr_pc;
    logic            w_unused_jr_lsb;

    assign w_kmode   = pc[KMODE_BIT];

    // Low 31 bits wrap on their own; the mode bit is never carried into.
    assign w_seq_low = pc[30:0] + 31'd4;
    assign pc_plus4  = {w_kmode, w_seq_low};

    assign w_br_low  = w_seq_low + branch_offset(branch_imm);
    assign w_br_pc   = {w_kmode, w_br_low};
    assign w_jump_pc = {w_kmode, w_seq_low[30:28], jump_target, 2'b00};

    // jr is the only path allowed to change the mode bit (return from handler).
    assign w_jr_pc         = {jr_target[31:2], 2'b00};
    assign w_unused_jr_lsb = ^jr_target[1:0];

    // Trap requests are honoured only in user mode and never while stalled.
    always_comb begin
        take_irq = 1'b0;
        take_exc = 1'b0;
        next_pc  = pc_plus4;
        if (stall) begin
            next_pc = pc;
        end else if (irq && !w_kmode) begin
            take_irq = 1'b1;
            next_pc  = IRQ_VEC;
        end else if (illegal_op && !w_kmode) begin
            take_exc = 1'b1;
            next_pc  = EXC_VEC;
        end else if (jr) begin
            next_pc  = w_jr_pc;
        end else if (jump) begin
            next_pc  = w_jump_pc;
        end else if (branch_taken) begin
            next_pc  = w_br_pc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_unit
//  Description : Program-counter stage. Holds PC (fetch address, bit 31 is
//                the kernel-mode flag) and the retired-instruction counter;
//                next-PC selection lives in next_pc_calc.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        irq,
    input  logic        illegal_op,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        take_irq,
    output logic        take_exc,
    output logic [31:0] epc,
    output logic [31:0] retired
);

    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_retired;
    logic [PC_W-1:0] w_next_pc;
    logic            w_take_irq;
    logic            w_take_exc;

    next_pc_calc #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_next_pc_calc (
        .pc           (r_pc),
        .stall        (stall),
        .irq          (irq),
        .illegal_op   (illegal_op),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .next_pc      (w_next_pc),
        .pc_plus4     (pc_plus4),
        .take_irq     (w_take_irq),
        .take_exc     (w_take_exc)
    );

    // A trap cannot be taken on a reset edge, so the datapath is told nothing.
    assign take_irq = w_take_irq & ~reset;
    assign take_exc = w_take_exc & ~reset;

    // The interrupted/faulting instruction is re-executed on return.
    assign epc      = r_pc;
    assign pc       = r_pc;
    assign retired  = r_retired;

    // PC update: reset beats stall; otherwise take the selected next PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_VEC;
        end else if (!stall) begin
            r_pc <= w_next_pc;
        end
    end

    // Count an instruction only when it completes (no stall, no trap).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= 32'd0;
        end else if (!stall && !w_take_irq && !w_take_exc) begin
            r_retired <= r_retired + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_unit
//  Description : Self-checking bench for pc_fetch_unit: directed scenarios
//                followed by randomized control traffic, compared against an
//                arithmetic reference model of the PC/retired behaviour.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] C_RESET = 32'h8000_0000;
    localparam logic [31:0] C_IRQ   = 32'h8000_0004;
    localparam logic [31:0] C_EXC   = 32'h8000_0008;
    localparam logic [31:0] C_KBIT  = 32'h8000_0000;
    localparam logic [31:0] C_LOW   = 32'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, stall, irq, illegal_op, branch_taken, jump, jr;
    logic [15:0] branch_imm;
    logic [25:0] jump_target;
    logic [31:0] jr_target;
    logic [31:0] pc, pc_plus4, epc, retired;
    logic        take_irq, take_exc;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ret;

    pc_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .irq          (irq),
        .illegal_op   (illegal_op),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_target  (jump_target),
        .jr           (jr),
        .jr_target    (jr_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .take_irq     (take_irq),
        .take_exc     (take_exc),
        .epc          (epc),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset        = 1'b0;
        stall        = 1'b0;
        irq          = 1'b0;
        illegal_op   = 1'b0;
        branch_taken = 1'b0;
        branch_imm   = 16'h0;
        jump         = 1'b0;
        jump_target  = 26'h0;
        jr           = 1'b0;
        jr_target    = 32'h0;
    endtask

    // One clock: check outputs against the model mid-cycle, predict the edge.
    task automatic step();
        logic        kern;
        logic        e_irq, e_exc;
        logic [31:0] seq;
        logic [31:0] offs;
        @(negedge clk);
        kern  = m_pc >= C_KBIT;
        e_irq = !reset && !stall && irq && !kern;
        e_exc = !reset && !stall && !e_irq && illegal_op && !kern;
        seq   = (m_pc & C_KBIT) | ((m_pc + 32'd4) & C_LOW);
        check_val("pc",       pc,       m_pc);
        check_val("pc_plus4", pc_plus4, seq);
        check_val("epc",      epc,      m_pc);
        check_val("retired",  retired,  m_ret);
        if (!reset) begin
            check_val("take_irq", {31'd0, take_irq}, {31'd0, e_irq});
            check_val("take_exc", {31'd0, take_exc}, {31'd0, e_exc});
        end
        if (reset) begin
            m_pc  = C_RESET;
            m_ret = 0;
        end else if (!stall) begin
            if (e_irq)       m_pc = C_IRQ;
            else if (e_exc)  m_pc = C_EXC;
            else if (jr)     m_pc = jr_target & 32'hFFFF_FFFC;
            else if (jump)   m_pc = (m_pc & C_KBIT) | ((m_pc + 32'd4) & 32'h7000_0000)
                                    | ({6'd0, jump_target} * 32'd4);
            else if (branch_taken) begin
                offs = 32'($signed({{16{branch_imm[15]}}, branch_imm}) * 4);
                m_pc = (m_pc & C_KBIT) | ((m_pc + 32'd4 + offs) & C_LOW);
            end else         m_pc = seq;
            if (!e_irq && !e_exc) m_ret = m_ret + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic go_jr(input logic [31:0] t);
        idle(); jr = 1'b1; jr_target = t; step(); idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_pc  = C_RESET;
        m_ret = 0;
        idle();

        // Reset release and sequential fetch
        check_val("rst_pc", pc, 32'h8000_0000);
        check_val("rst_ret", retired, 32'd0);
        repeat (3) step();
        check_val("seq_pc", pc, 32'h8000_000C);

        // jr into user space, then sequential
        go_jr(32'h0000_0024);
        check_val("jr_pc", pc, 32'h0000_0024);
        step();
        step();
        check_val("seq_user", pc, 32'h0000_002C);

        // Branch self-loop and forward branch
        branch_taken = 1'b1; branch_imm = 16'hFFFF; step();
        check_val("br_loop", pc, 32'h0000_002C);
        branch_imm = 16'h0003; step(); idle();
        check_val("br_fwd", pc, 32'h0000_003C);

        // Jumps from user and kernel
        go_jr(32'h0000_0028);
        jump = 1'b1; jump_target = 26'h000000C; step(); idle();
        check_val("j_user", pc, 32'h0000_0030);
        go_jr(32'h8000_0010);
        jump = 1'b1; jump_target = 26'h000000C; step(); idle();
        check_val("j_kern", pc, 32'h8000_0030);

        // irq + illegal_op in user mode: irq wins
        go_jr(32'h0000_0040);
        irq = 1'b1; illegal_op = 1'b1; step();
        illegal_op = 1'b0;
        check_val("irq_pc", pc, C_IRQ);
        repeat (3) step();      // irq held in kernel: ignored
        idle();

        // Stall with pending irq, then release
        go_jr(32'h0000_0050);
        irq = 1'b1; stall = 1'b1;
        repeat (3) step();
        check_val("stall_pc", pc, 32'h0000_0050);
        stall = 1'b0; step(); idle();
        check_val("irq_after_stall", pc, C_IRQ);

        // Reset during stall
        go_jr(32'h0000_0050);
        stall = 1'b1; irq = 1'b1; step();
        reset = 1'b1; step(); idle();
        check_val("rst_in_stall", pc, C_RESET);

        // Illegal op in user mode and in kernel mode
        go_jr(32'h0000_0100);
        illegal_op = 1'b1; step();
        check_val("exc_pc", pc, C_EXC);
        step(); idle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 99) < 2);
            stall        = ($urandom_range(0, 99) < 10);
            irq          = ($urandom_range(0, 99) < 8);
            illegal_op   = ($urandom_range(0, 99) < 8);
            branch_taken = ($urandom_range(0, 99) < 25);
            branch_imm   = 16'($urandom);
            jump         = ($urandom_range(0, 99) < 15);
            jump_target  = 26'($urandom);
            jr           = ($urandom_range(0, 99) < 15);
            jr_target    = $urandom;
            step();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
